// File: rtl/xvec2_vscale_vecfile_nl.sv
// Vector register file: LANES elements per register, two combinational read
// ports, one masked write port with same-cycle bypass, and a hardware clear
// sequence that zeroes registers 1..NREGS-1. The clear sequence also runs after reset.
module xvec2_vscale_vecfile_nl #(
    parameter int XPR_LEN = 32,
    parameter int LANES   = 4,
    parameter int NREGS   = 8,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [AW-1:0]            ra1,
    output logic [LANES*XPR_LEN-1:0] rd1,
    input  logic [AW-1:0]            ra2,
    output logic [LANES*XPR_LEN-1:0] rd2,
    input  logic                     wen,
    input  logic [AW-1:0]            wa,
    input  logic [LANES-1:0]         wmask,
    input  logic [LANES*XPR_LEN-1:0] wd,
    input  logic                     clr_req,
    output logic                     busy,
    output logic                     clr_done,
    output logic                     wr_drop
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    state_t              state;
    logic [AW-1:0]       cnt;
    logic [XPR_LEN-1:0]  mem [NREGS][LANES];
    logic                write_ok;

    // A write is only honoured while idle; register 0 is hardwired to zero.
    assign write_ok = (state == IDLE) && wen && (wa != '0);

    // Status flags come straight from the registered state; reset masks the
    // two pulse-style flags so they stay low while reset is held.
    assign busy     = (state == CLEAR);
    assign clr_done = busy && (cnt == LAST_IDX) && !reset;
    assign wr_drop  = busy && wen && (wa != '0) && !reset;

    // Clear sequencer: reset (or a request while idle) walks cnt from 1 to NREGS-1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= CLEAR;
            cnt   <= AW'(1);
        end else begin
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state <= CLEAR;
                        cnt   <= AW'(1);
                    end
                end
                CLEAR: begin
                    if (cnt == LAST_IDX) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + AW'(1);
                    end
                end
                default: begin
                    state <= CLEAR;
                    cnt   <= AW'(1);
                end
            endcase
        end
    end

    // Storage update: clearing takes precedence; otherwise masked lane writes.
    // Once reset is seen the state is already CLEAR, so no pending write lands.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            for (int l = 0; l < LANES; l++) begin
                mem[cnt][l] <= '0;
            end
        end else if (write_ok) begin
            for (int l = 0; l < LANES; l++) begin
                if (wmask[l]) begin
                    mem[wa][l] <= wd[l*XPR_LEN +: XPR_LEN];
                end
            end
        end
    end

    // Combinational read with per-lane forwarding of an in-flight idle write.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        for (int l = 0; l < LANES; l++) begin
            if (ra1 != '0) begin
                if (write_ok && (ra1 == wa) && wmask[l]) begin
                    rd1[l*XPR_LEN +: XPR_LEN] = wd[l*XPR_LEN +: XPR_LEN];
                end else begin
                    rd1[l*XPR_LEN +: XPR_LEN] = mem[ra1][l];
                end
            end
            if (ra2 != '0) begin
                if (write_ok && (ra2 == wa) && wmask[l]) begin
                    rd2[l*XPR_LEN +: XPR_LEN] = wd[l*XPR_LEN +: XPR_LEN];
                end else begin
                    rd2[l*XPR_LEN +: XPR_LEN] = mem[ra2][l];
                end
            end
        end
    end

endmodule

// File: tb/tb_xvec2_vscale_vecfile_nl.sv
// Directed bench for xvec2_vscale_vecfile_nl with default parameters.
module tb_xvec2_vscale_vecfile_nl;

    localparam int XL = 32;
    localparam int LN = 4;
    localparam int NR = 8;
    localparam int AW = 3;

    logic              clk;
    logic              reset;
    logic [AW-1:0]     ra1, ra2, wa;
    logic [LN*XL-1:0]  rd1, rd2, wd;
    logic              wen;
    logic [LN-1:0]     wmask;
    logic              clr_req;
    logic              busy, clr_done, wr_drop;

    int n_tests = 0;
    int n_fail  = 0;

    xvec2_vscale_vecfile_nl #(.XPR_LEN(XL), .LANES(LN), .NREGS(NR)) dut (
        .clk(clk), .reset(reset),
        .ra1(ra1), .rd1(rd1), .ra2(ra2), .rd2(rd2),
        .wen(wen), .wa(wa), .wmask(wmask), .wd(wd),
        .clr_req(clr_req), .busy(busy), .clr_done(clr_done), .wr_drop(wr_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Idle-mode write helper (stimulus only).
    task automatic do_write(input logic [AW-1:0] a, input logic [LN-1:0] m,
                            input logic [LN*XL-1:0] d);
        wen = 1'b1; wa = a; wmask = m; wd = d;
        tick();
        wen = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; clr_req = 1'b0;
        wen = 1'b1; wa = 3'd2; wmask = 4'hf; wd = '1;
        ra1 = 3'd0; ra2 = 3'd0;
        #2;
        tick(); tick();
        n_tests++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b expected 1", busy); end
        n_tests++;
        if (clr_done !== 1'b0) begin n_fail++; $display("FAIL reset_clr_done: got %b expected 0", clr_done); end
        n_tests++;
        if (wr_drop !== 1'b0) begin n_fail++; $display("FAIL reset_wr_drop: got %b expected 0", wr_drop); end
        wen = 1'b0;
        reset = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            #1;
            n_tests++;
            if (busy !== 1'b1) begin n_fail++; $display("FAIL rel_busy_c%0d: got %b expected 1", k, busy); end
            n_tests++;
            if (clr_done !== (k == 7)) begin n_fail++; $display("FAIL rel_clr_done_c%0d: got %b expected %b", k, clr_done, (k == 7)); end
            tick();
        end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rel_idle_busy: got %b expected 0", busy); end
        for (int r = 0; r < NR; r++) begin
            ra1 = AW'(r); ra2 = AW'(r);
            #1;
            n_tests++;
            if (rd1 !== '0 || rd2 !== '0) begin
                n_fail++; $display("FAIL rel_zero_r%0d: got %h/%h expected 0", r, rd1, rd2);
            end
        end
    endtask

    task automatic test_masked_write();
        logic [LN*XL-1:0] nines, exp_v;
        nines = {32'h9, 32'h9, 32'h9, 32'h9};
        exp_v = {32'h9, 32'h33333333, 32'h9, 32'h11111111};
        ra1 = 3'd3; ra2 = 3'd4;
        do_write(3'd3, 4'hf, nines);
        #1;
        n_tests++;
        if (rd1 !== nines) begin n_fail++; $display("FAIL mw_init: got %h expected %h", rd1, nines); end
        wen = 1'b1; wa = 3'd3; wmask = 4'b0101;
        wd = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        #1;
        n_tests++;
        if (rd1 !== exp_v) begin n_fail++; $display("FAIL mw_bypass: got %h expected %h", rd1, exp_v); end
        n_tests++;
        if (rd2 !== '0) begin n_fail++; $display("FAIL mw_other_reg: got %h expected 0", rd2); end
        tick();
        wen = 1'b0;
        #1;
        n_tests++;
        if (rd1 !== exp_v) begin n_fail++; $display("FAIL mw_stored: got %h expected %h", rd1, exp_v); end
    endtask

    task automatic test_reg0();
        ra1 = 3'd0; ra2 = 3'd0;
        wen = 1'b1; wa = 3'd0; wmask = 4'hf; wd = '1;
        #1;
        n_tests++;
        if (rd1 !== '0) begin n_fail++; $display("FAIL r0_bypass: got %h expected 0", rd1); end
        n_tests++;
        if (wr_drop !== 1'b0) begin n_fail++; $display("FAIL r0_wr_drop: got %b expected 0", wr_drop); end
        tick();
        wen = 1'b0;
        #1;
        n_tests++;
        if (rd1 !== '0 || rd2 !== '0) begin n_fail++; $display("FAIL r0_stored: got %h/%h expected 0", rd1, rd2); end
    endtask

    task automatic test_clear_collision();
        logic [LN*XL-1:0] v2, w5;
        v2 = {32'ha5a50002, 32'ha5a50002, 32'ha5a50002, 32'ha5a50002};
        w5 = {32'h55550005, 32'h55550005, 32'h55550005, 32'h55550005};
        do_write(3'd2, 4'hf, v2);
        clr_req = 1'b1; wen = 1'b1; wa = 3'd5; wmask = 4'hf; wd = w5;
        #1;
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL cc_pre_busy: got %b expected 0", busy); end
        tick();
        clr_req = 1'b0; wen = 1'b0; ra1 = 3'd5; ra2 = 3'd2;
        #1;
        n_tests++;
        if (rd1 !== w5) begin n_fail++; $display("FAIL cc_reg5_written: got %h expected %h", rd1, w5); end
        for (int k = 1; k <= 7; k++) begin
            wen = 1'b0; clr_req = 1'b0;
            if (k == 1) begin
                wen = 1'b1; wa = 3'd2; wmask = 4'hf; wd = '1;
                #1;
                n_tests++;
                if (wr_drop !== 1'b1) begin n_fail++; $display("FAIL cc_wr_drop: got %b expected 1", wr_drop); end
                n_tests++;
                if (rd2 !== v2) begin n_fail++; $display("FAIL cc_no_bypass: got %h expected %h", rd2, v2); end
            end else if (k == 2) begin
                wen = 1'b1; wa = 3'd0;
                #1;
                n_tests++;
                if (wr_drop !== 1'b0) begin n_fail++; $display("FAIL cc_wr_drop_r0: got %b expected 0", wr_drop); end
                n_tests++;
                if (rd2 !== v2) begin n_fail++; $display("FAIL cc_reg2_unchanged: got %h expected %h", rd2, v2); end
            end else if (k == 4) begin
                clr_req = 1'b1;
            end
            #1;
            n_tests++;
            if (busy !== 1'b1) begin n_fail++; $display("FAIL cc_busy_c%0d: got %b expected 1", k, busy); end
            n_tests++;
            if (clr_done !== (k == 7)) begin n_fail++; $display("FAIL cc_clr_done_c%0d: got %b expected %b", k, clr_done, (k == 7)); end
            tick();
        end
        wen = 1'b0; clr_req = 1'b0;
        #1;
        n_tests++;
        if (busy !== 1'b0 || clr_done !== 1'b0) begin n_fail++; $display("FAIL cc_idle: got busy=%b done=%b expected 0/0", busy, clr_done); end
        n_tests++;
        if (rd1 !== '0 || rd2 !== '0) begin n_fail++; $display("FAIL cc_cleared: got %h/%h expected 0", rd1, rd2); end
        ra1 = 3'd3;
        #1;
        n_tests++;
        if (rd1 !== '0) begin n_fail++; $display("FAIL cc_reg3_cleared: got %h expected 0", rd1); end
    endtask

    task automatic test_reset_mid();
        logic [LN*XL-1:0] v6;
        v6 = {32'h66660006, 32'h66660006, 32'h66660006, 32'h66660006};
        do_write(3'd6, 4'hf, v6);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        tick(); tick(); tick();
        ra1 = 3'd6;
        #1;
        n_tests++;
        if (rd1 !== v6) begin n_fail++; $display("FAIL rm_reg6_old: got %h expected %h", rd1, v6); end
        reset = 1'b1;
        #1;
        n_tests++;
        if (busy !== 1'b1 || clr_done !== 1'b0) begin n_fail++; $display("FAIL rm_async: got busy=%b done=%b expected 1/0", busy, clr_done); end
        tick();
        reset = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            #1;
            n_tests++;
            if (busy !== 1'b1) begin n_fail++; $display("FAIL rm_busy_c%0d: got %b expected 1", k, busy); end
            n_tests++;
            if (clr_done !== (k == 7)) begin n_fail++; $display("FAIL rm_clr_done_c%0d: got %b expected %b", k, clr_done, (k == 7)); end
            tick();
        end
        #1;
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_idle_busy: got %b expected 0", busy); end
        n_tests++;
        if (rd1 !== '0) begin n_fail++; $display("FAIL rm_reg6_cleared: got %h expected 0", rd1); end
    endtask

    task automatic test_back_to_back();
        logic [LN*XL-1:0] e1, e7;
        e1 = {32'h0, 32'h0, 32'h2, 32'h1};
        e7 = {32'hd7d7d7d7, 32'h0, 32'h0, 32'h0};
        ra1 = 3'd1; ra2 = 3'd7;
        wen = 1'b1; wa = 3'd1; wmask = 4'b0011; wd = {32'h4, 32'h3, 32'h2, 32'h1};
        tick();
        wa = 3'd7; wmask = 4'b1000; wd = {32'hd7d7d7d7, 32'h3, 32'h2, 32'h1};
        #1;
        n_tests++;
        if (rd1 !== e1) begin n_fail++; $display("FAIL b2b_reg1: got %h expected %h", rd1, e1); end
        n_tests++;
        if (rd2 !== e7) begin n_fail++; $display("FAIL b2b_reg7_bypass: got %h expected %h", rd2, e7); end
        tick();
        wen = 1'b0;
        #1;
        n_tests++;
        if (rd2 !== e7) begin n_fail++; $display("FAIL b2b_reg7_stored: got %h expected %h", rd2, e7); end
    endtask

    initial begin
        test_reset();
        test_masked_write();
        test_reg0();
        test_clear_collision();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/xvec2_vscale_vecfile_nl.md
XVEC2_VSCALE_VECFILE_NL -- requirements
Module: xvec2_vscale_vecfile_nl

Interface
REQ-001 SHALL have parameter XPR_LEN, default 32: element (lane) width in bits.
REQ-002 SHALL have parameter LANES, default 4: elements per vector register, >=1.
REQ-003 SHALL have parameter NREGS, default 8: vector registers, power of 2, >=2; AW = log2(NREGS).
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 ra1  input  AW  read port 1 register index.
REQ-007 rd1  output  LANES*XPR_LEN  read data 1; lane i at bits [i*XPR_LEN +: XPR_LEN].
REQ-008 ra2  input  AW  read port 2 register index.
REQ-009 rd2  output  LANES*XPR_LEN  read data 2, same lane layout.
REQ-010 wen  input  1  write enable.
REQ-011 wa  input  AW  write register index.
REQ-012 wmask  input  LANES  per-lane write enable; bit i gates lane i.
REQ-013 wd  input  LANES*XPR_LEN  write data, same lane layout.
REQ-014 clr_req  input  1  request to zero registers 1..NREGS-1.
REQ-015 busy  output  1  clear sequence in progress.
REQ-016 clr_done  output  1  one-cycle pulse in last clear cycle.
REQ-017 wr_drop  output  1  one-cycle flag: write rejected because busy.

Function
REQ-018 Storage SHALL be NREGS*LANES elements of XPR_LEN bits, no reset on the array itself.
REQ-019 Register 0 SHALL read as all zeros on both ports regardless of stored contents; writes to wa=0 SHALL have no effect.
REQ-020 Reads SHALL be combinational from ra1/ra2 (zero latency).
REQ-021 In IDLE, wen=1 with wa!=0 SHALL update, at the clock edge, only lanes i with wmask[i]=1 to wd lane i; other lanes unchanged.
REQ-022 Bypass: when in IDLE, wen=1, wa!=0 and ra==wa, rd SHALL return wd lane i for lanes with wmask[i]=1 and stored lane i otherwise, same cycle.
REQ-023 FSM states SHALL be IDLE and CLEAR, with index counter cnt of AW bits.
REQ-024 IDLE -> CLEAR when clr_req=1 at an edge; cnt loads 1; any concurrent IDLE write in that cycle SHALL still complete.
REQ-025 In CLEAR, each edge SHALL zero all LANES of register cnt and increment cnt.
REQ-026 CLEAR -> IDLE at the edge where cnt=NREGS-1 is cleared; total CLEAR duration exactly NREGS-1 cycles.
REQ-027 busy SHALL equal (state==CLEAR), registered-state derived, no combinational path from inputs.
REQ-028 clr_done SHALL be 1 exactly in the CLEAR cycle with cnt=NREGS-1, 0 otherwise.
REQ-029 In CLEAR, wen SHALL be ignored (no array update, no bypass) and wr_drop SHALL be 1 in each such cycle where wen=1 and wa!=0.
REQ-030 clr_req while in CLEAR SHALL be ignored; sequence neither restarts nor extends.
REQ-031 Reads during CLEAR SHALL return current array contents (cleared regs read 0, uncleared regs old value).
REQ-032 NREGS=2 SHALL yield a single-cycle CLEAR with busy and clr_done both high that cycle.

Reset
REQ-033 While reset=1 (asynchronously on assertion): state=CLEAR, cnt=1, busy=1, clr_done=0, wr_drop=0.
REQ-034 After reset deasserts, the clear sequence SHALL run from cnt=1 automatically, so all registers read 0 by the first IDLE cycle.
REQ-035 Reset asserted mid-CLEAR or mid-write SHALL abort and restart clear from cnt=1; no partial write completes after the asserting edge.

Verification
REQ-036 Reset release, defaults (NREGS=8) -> busy=1 for 7 cycles, clr_done in 7th, then ra1=1..7 all read 0.
REQ-037 IDLE: wa=3, wmask=4'b0101, wd=lanes {D,C,B,A}=0x44..,0x33..,0x22..,0x11.. over old {9,9,9,9} -> rd1(ra1=3) same cycle {9,C,9,A} via bypass, next cycle stored {9,C,9,A}.
REQ-038 Write wa=0 wd=all-ones wmask=all -> rd1(ra1=0)=0 same and next cycle; wr_drop=0.
REQ-039 clr_req with simultaneous wen wa=5 -> reg5 written that edge, busy next cycle, reg5 reads 0 after clear; wen wa=2 during CLEAR -> wr_drop=1, reg2 unchanged.
REQ-040 clr_req pulsed again at cnt=4 -> ignored, clr_done still on 7th CLEAR cycle.
REQ-041 Reset asserted at cnt=4 -> busy stays 1, cnt=1 asynchronously; full 7-cycle sequence repeats after release.
